mem_master: RTL

- Initiator-side memory access controller between the CPU load/store unit and the 64-bit big-endian RAM bus (clk, wr, addr, 64-bit bidirectional data).
- Accepts byte/half/word/double load and store requests over a valid/ready handshake and drives the RAM bus.
- Sub-doubleword stores use read-modify-write, because the RAM always writes 8 bytes.
- Returns zero- or sign-extended load data over a valid/ready response channel.

---
 rtl/mem_master_if.sv | 36 +++
 rtl/mem_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_master_if
//  Description : Request/response handshake bundle between the load/store unit
//                and the mem_master RAM controller.
//  Revision    : 1.0
// ============================================================================
interface mem_master_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_rdata;
    logic              resp_err;

    // Requester side (load/store unit)
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    // Controller side (mem_master)
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_master
//  Description : Load/store controller for a 64-bit big-endian RAM bus with
//                read-modify-write for sub-doubleword stores.
//                Optional macro MEM_MASTER_ALIGN_CHECK_EN rejects unaligned
//                accesses with resp_err.
//  Revision    : 1.0
// ============================================================================
module mem_master #(
    parameter int ADDR_W      = 64,
    parameter int TIMEOUT_CYC = 0
) (
    input  wire                clk,
    input  wire                rst,
    mem_master_if.slave        bus,
    output logic               mem_wr,
    output logic [ADDR_W-1:0]  mem_addr,
    inout  wire  [63:0]        mem_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [63:0]       r_wdata;
    logic [63:0]       r_mem_dout;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [63:0]       r_resp_rdata;
    logic              r_resp_err;

    logic              w_accept;
    logic              w_misaligned;
    logic [63:0]       w_loaded;
    logic [63:0]       w_merged;

    if (TIMEOUT_CYC != 0) begin : g_timeout_unsupported
        $error("mem_master: TIMEOUT_CYC is reserved and must be 0");
    end

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

`ifdef MEM_MASTER_ALIGN_CHECK_EN
    logic [2:0] w_size_mask;
    assign w_size_mask  = 3'((4'd1 << bus.req_size) - 4'd1);
    assign w_misaligned = |(bus.req_addr[2:0] & w_size_mask);
`else
    assign w_misaligned = 1'b0;
`endif

    // The accessed bytes sit in the top of the bus word (big-endian).
    always_comb begin
        w_loaded = mem_data;
        w_merged = r_wdata;
        unique case (r_size)
            2'd0: begin
                w_loaded = {{56{r_signed & mem_data[63]}}, mem_data[63:56]};
                w_merged = {r_wdata[7:0], mem_data[55:0]};
            end
            2'd1: begin
                w_loaded = {{48{r_signed & mem_data[63]}}, mem_data[63:48]};
                w_merged = {r_wdata[15:0], mem_data[47:0]};
            end
            2'd2: begin
                w_loaded = {{32{r_signed & mem_data[63]}}, mem_data[63:32]};
                w_merged = {r_wdata[31:0], mem_data[31:0]};
            end
            default: begin
                w_loaded = mem_data;
                w_merged = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (w_misaligned) begin
                        w_state_next = S_RESP;
                    end else if (bus.req_we && (bus.req_size == 2'd3)) begin
                        w_state_next = S_WR;
                    end else begin
                        w_state_next = S_RD;
                    end
                end
            end
            S_RD:    w_state_next = r_we ? S_WR : S_RESP;
            S_WR:    w_state_next = S_RESP;
            S_RESP:  w_state_next = bus.resp_ready ? S_IDLE : S_RESP;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_size       <= 2'd0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_mem_dout   <= '0;
            r_mem_wr     <= 1'b0;
            r_mem_addr   <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_mem_wr <= (w_state_next == S_WR);
            if (w_accept) begin
                r_we         <= bus.req_we;
                r_size       <= bus.req_size;
                r_signed     <= bus.req_signed;
                r_wdata      <= bus.req_wdata;
                r_mem_addr   <= bus.req_addr;
                r_mem_dout   <= bus.req_wdata;
                r_resp_rdata <= '0;
                r_resp_err   <= w_misaligned;
            end else if (r_state == S_RD) begin
                if (r_we) begin
                    r_mem_dout <= w_merged;
                end else begin
                    r_resp_rdata <= w_loaded;
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = (r_state == S_RESP);
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;

    assign mem_wr   = r_mem_wr;
    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_wr ? r_mem_dout : {64{1'bz}};

endmodule
`default_nettype wire
